// File: rtl/nonce_sched_pkg.sv
// Shared widths and FSM state encoding for the nonce scheduler.
package nonce_sched_pkg;

  localparam int NONCE_W = 32;
  localparam int BLOCK_W = 512;
  localparam int HASH_W  = 256;
  localparam int CNT_W   = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    WAIT,
    CHECK,
    REPORT
  } state_t;

endpackage

// File: rtl/nonce_sched_cmp.sv
// Registered unsigned magnitude compare: o_lt holds (i_a < i_b) from the last enabled cycle.
module nonce_sched_cmp
  import nonce_sched_pkg::*;
#(
  parameter int W = HASH_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_lt
);

  logic r_lt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_lt <= 1'b0;
    else if (i_en) r_lt <= (i_a < i_b);
  end

  assign o_lt = r_lt;

endmodule

// File: rtl/nonce_sched.sv
// Job controller stepping a SHA256 core over a nonce range until hash < target.
// Build option NONCE_SCHED_WATCHDOG_EN: retry the current nonce if the core hangs in WAIT.
module nonce_sched #(
  parameter int NONCE_W      = nonce_sched_pkg::NONCE_W,
  parameter int NONCE_LSB    = 96,
  parameter int CORE_TIMEOUT = 4096
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                job_valid,
  output logic                                job_ready,
  input  logic [nonce_sched_pkg::BLOCK_W-1:0] job_block,
  input  logic [nonce_sched_pkg::HASH_W-1:0]  job_target,
  input  logic [NONCE_W-1:0]                  job_nstart,
  input  logic [NONCE_W-1:0]                  job_nend,
  input  logic                                abort,
  output logic                                sha_reset,
  output logic                                sha_start,
  output logic [nonce_sched_pkg::BLOCK_W-1:0] sha_block,
  input  logic [nonce_sched_pkg::HASH_W-1:0]  sha_hash,
  input  logic                                sha_done,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic                                res_found,
  output logic [NONCE_W-1:0]                  res_nonce,
  output logic [nonce_sched_pkg::HASH_W-1:0]  res_hash,
  output logic                                busy,
  output logic [nonce_sched_pkg::CNT_W-1:0]   hash_count
);
  import nonce_sched_pkg::*;

`ifdef NONCE_SCHED_WATCHDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif
  localparam int WDOG_W = $clog2(CORE_TIMEOUT + 1);

  state_t               r_state;
  logic [BLOCK_W-1:0]   r_block;
  logic [BLOCK_W-1:0]   r_sha_block;
  logic [HASH_W-1:0]    r_target;
  logic [HASH_W-1:0]    r_hash;
  logic [NONCE_W-1:0]   r_nonce;
  logic [NONCE_W-1:0]   r_nend;
  logic [WDOG_W-1:0]    r_wdog;
  logic                 r_abort_rst;
  logic                 r_res_valid;
  logic                 r_res_found;
  logic [NONCE_W-1:0]   r_res_nonce;
  logic [HASH_W-1:0]    r_res_hash;
  logic [CNT_W-1:0]     r_hash_count;

  logic                 w_active;
  logic                 w_abort;
  logic                 w_cmp_en;
  logic                 w_lt;
  logic [NONCE_W-1:0]   w_nonce_nxt;
  logic                 w_wdog_hit;

  function automatic logic [BLOCK_W-1:0] ins_nonce(input logic [BLOCK_W-1:0] blk,
                                                   input logic [NONCE_W-1:0] n);
    logic [BLOCK_W-1:0] b;
    b = blk;
    b[NONCE_LSB +: NONCE_W] = n;
    return b;
  endfunction

  assign w_active    = (r_state == CLEAR) || (r_state == ISSUE) ||
                       (r_state == WAIT)  || (r_state == CHECK);
  assign w_abort     = abort && w_active;
  assign w_cmp_en    = (r_state == WAIT) && sha_done;
  assign w_nonce_nxt = r_nonce + 1'b1;
  assign w_wdog_hit  = WDOG_EN && (r_wdog == WDOG_W'(CORE_TIMEOUT - 1));

  // Compare straight off the core bus on the done cycle so the verdict is ready in CHECK.
  nonce_sched_cmp #(.W(HASH_W)) u_cmp (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_cmp_en),
    .i_a   (sha_hash),
    .i_b   (r_target),
    .o_lt  (w_lt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_block      <= '0;
      r_sha_block  <= '0;
      r_target     <= '0;
      r_hash       <= '0;
      r_nonce      <= '0;
      r_nend       <= '0;
      r_wdog       <= '0;
      r_abort_rst  <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_found  <= 1'b0;
      r_res_nonce  <= '0;
      r_res_hash   <= '0;
      r_hash_count <= '0;
    end else begin
      r_abort_rst <= 1'b0;
      if (w_abort) begin
        // Abort beats a same-cycle done; the current nonce is reported unhashed.
        r_abort_rst <= 1'b1;
        r_res_found <= 1'b0;
        r_res_nonce <= r_nonce;
        r_res_hash  <= (r_state == CHECK) ? r_hash : '0;
        r_res_valid <= 1'b1;
        r_state     <= REPORT;
      end else begin
        case (r_state)
          IDLE: begin
            if (job_valid) begin
              r_block     <= job_block;
              r_target    <= job_target;
              r_nonce     <= job_nstart;
              r_nend      <= job_nend;
              r_sha_block <= ins_nonce(job_block, job_nstart);
              r_state     <= CLEAR;
            end
          end
          CLEAR: r_state <= ISSUE;
          ISSUE: begin
            r_wdog  <= '0;
            r_state <= WAIT;
          end
          WAIT: begin
            if (sha_done) begin
              r_hash  <= sha_hash;
              r_state <= CHECK;
            end else if (w_wdog_hit) begin
              r_state <= CLEAR;
            end else begin
              r_wdog <= r_wdog + 1'b1;
            end
          end
          CHECK: begin
            r_hash_count <= r_hash_count + 1'b1;
            if (w_lt || (r_nonce == r_nend)) begin
              r_res_found <= w_lt;
              r_res_nonce <= r_nonce;
              r_res_hash  <= r_hash;
              r_res_valid <= 1'b1;
              r_state     <= REPORT;
            end else begin
              r_nonce     <= w_nonce_nxt;
              r_sha_block <= ins_nonce(r_block, w_nonce_nxt);
              r_state     <= CLEAR;
            end
          end
          REPORT: begin
            if (res_ready) begin
              r_res_valid <= 1'b0;
              r_state     <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign job_ready  = (r_state == IDLE) && !reset;
  assign busy       = (r_state != IDLE);
  assign sha_reset  = reset || (r_state == CLEAR) || r_abort_rst;
  assign sha_start  = (r_state == ISSUE);
  assign sha_block  = r_sha_block;
  assign res_valid  = r_res_valid;
  assign res_found  = r_res_found;
  assign res_nonce  = r_res_nonce;
  assign res_hash   = r_res_hash;
  assign hash_count = r_hash_count;

endmodule

// File: tb/tb_nonce_sched.sv
// Randomized scoreboard bench for nonce_sched with a behavioural SHA-core stand-in.
module tb_nonce_sched;
  localparam int LSB = 96;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [511:0] job_block = '0;
  logic [255:0] job_target = '0;
  logic [31:0]  job_nstart = '0;
  logic [31:0]  job_nend = '0;
  logic         abort = 1'b0;
  logic         sha_reset, sha_start;
  logic [511:0] sha_block;
  logic [255:0] sha_hash = '0;
  logic         sha_done = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic         res_found;
  logic [31:0]  res_nonce;
  logic [255:0] res_hash;
  logic         busy;
  logic [31:0]  hash_count;

  nonce_sched #(.NONCE_W(32), .NONCE_LSB(LSB), .CORE_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .job_block(job_block), .job_target(job_target), .job_nstart(job_nstart),
    .job_nend(job_nend), .abort(abort), .sha_reset(sha_reset), .sha_start(sha_start),
    .sha_block(sha_block), .sha_hash(sha_hash), .sha_done(sha_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found),
    .res_nonce(res_nonce), .res_hash(res_hash), .busy(busy), .hash_count(hash_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         found;
    logic [31:0]  nonce;
    logic [255:0] hash;
    logic [31:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   m_cnt = 0;
  int   core_lat = 4;
  int   drop_idx = -1;
  int   done_idx = 0;
  int   c_cnt = 0;
  logic c_busy = 1'b0;
  logic ready_hold = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] core_hash(input logic [511:0] b);
    logic [31:0]  x;
    logic [255:0] h;
    x = 32'h6a09e667;
    for (int i = 0; i < 16; i++) begin
      x = (x ^ b[i*32 +: 32]) * 32'h01000193 + 32'(i);
      x = x ^ (x >> 15);
    end
    for (int k = 0; k < 8; k++) begin
      x = x * 32'h9E3779B1 + 32'h7F4A7C15;
      x = x ^ (x >> 13);
      h[k*32 +: 32] = x;
    end
    return h;
  endfunction

  function automatic logic [511:0] with_nonce(input logic [511:0] b, input logic [31:0] n);
    logic [511:0] r;
    r = b;
    r[LSB +: 32] = n;
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: walk the inclusive (possibly wrapping) range, first hash below target wins.
  task automatic model_job(input logic [511:0] b, input logic [255:0] t,
                           input logic [31:0] ns, input logic [31:0] ne, output exp_t e);
    logic [31:0]  n;
    logic [255:0] h;
    n = ns;
    e = '0;
    for (int k = 0; k < 100000; k++) begin
      h = core_hash(with_nonce(b, n));
      m_cnt++;
      if (h < t || n == ne) begin
        e.found = (h < t);
        e.nonce = n;
        e.hash  = h;
        break;
      end
      n = n + 32'd1;
    end
    e.cnt = 32'(m_cnt);
  endtask

  // SHA core stand-in: done core_lat cycles after start, one done can be dropped on request.
  always @(posedge clk or posedge sha_reset) begin
    if (sha_reset) begin
      c_busy   <= 1'b0;
      c_cnt    <= 0;
      sha_done <= 1'b0;
    end else begin
      sha_done <= 1'b0;
      if (sha_start) begin
        c_busy <= 1'b1;
        c_cnt  <= core_lat;
      end else if (c_busy) begin
        if (c_cnt <= 1) begin
          c_busy   <= 1'b0;
          done_idx <= done_idx + 1;
          if (done_idx != drop_idx) begin
            sha_done <= 1'b1;
            sha_hash <= core_hash(sha_block);
          end
        end else begin
          c_cnt <= c_cnt - 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    res_ready = ready_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: every accepted result is checked against the oldest expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #1;
    if (!reset && res_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious res_valid", res_valid, 1'b0);
      end else if (res_ready) begin
        e = exp_q.pop_front();
        chk("res_found", res_found, e.found);
        chk("res_nonce", res_nonce, e.nonce);
        chk("res_hash", res_hash, e.hash);
        chk("hash_count", hash_count, e.cnt);
      end
    end
  end

  task automatic issue(input logic [511:0] b, input logic [255:0] t,
                       input logic [31:0] ns, input logic [31:0] ne, input int lat);
    core_lat = lat;
    for (int k = 0; k < 300 && !job_ready; k++) @(negedge clk);
    chk("job_ready before issue", job_ready, 1'b1);
    job_block  = b;
    job_target = t;
    job_nstart = ns;
    job_nend   = ne;
    job_valid  = 1'b1;
    @(negedge clk);
    job_valid  = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && job_ready) return;
    end
    chk("job completion timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_job(input logic [511:0] b, input logic [255:0] t,
                         input logic [31:0] ns, input logic [31:0] ne, input int lat);
    exp_t e;
    model_job(b, t, ns, ne, e);
    exp_q.push_back(e);
    issue(b, t, ns, ne, lat);
    wait_idle(5000);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global timeout: bench did not finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [511:0] blk;
    logic [255:0] tgt, h5, h6, h7;
    logic [31:0]  ns, ne;
    exp_t         e;
    int           base, sel;
    bit           hit;

    // Reset values
    #12;
    chk("rst busy", busy, 1'b0);
    chk("rst sha_start", sha_start, 1'b0);
    chk("rst res_valid", res_valid, 1'b0);
    chk("rst res_found", res_found, 1'b0);
    chk("rst res_nonce", res_nonce, 32'd0);
    chk("rst res_hash", res_hash, 256'd0);
    chk("rst hash_count", hash_count, 32'd0);
    chk("rst sha_block", sha_block, 512'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("job_ready after reset", job_ready, 1'b1);

    // 1: first win at nonce 7 inside 5..9, slow core
    blk = rand512();
    for (int k = 0; k < 200; k++) begin
      blk = rand512();
      h5 = core_hash(with_nonce(blk, 32'd5));
      h6 = core_hash(with_nonce(blk, 32'd6));
      h7 = core_hash(with_nonce(blk, 32'd7));
      if (h5 > h7 && h6 > h7 && h7 != '1) break;
    end
    run_job(blk, h7 + 256'd1, 32'd5, 32'd9, 64);
    chk("t1 nonce 7 found", res_nonce, 32'd7);
    chk("t1 three hashes", hash_count, 32'd3);

    // 2: no win, range wraps through zero
    run_job(rand512(), 256'd0, 32'hFFFF_FFFE, 32'd1, $urandom_range(1, 6));
    chk("t2 four hashes", hash_count, 32'd7);

    // 3: single nonce, result held while res_ready low
    ready_hold = 1'b1;
    blk = rand512();
    model_job(blk, '1, 32'h10, 32'h10, e);
    exp_q.push_back(e);
    issue(blk, '1, 32'h10, 32'h10, 3);
    for (int k = 0; k < 200 && !res_valid; k++) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t3 res_valid held", res_valid, 1'b1);
    end
    ready_hold = 1'b0;
    wait_idle(200);

    // 4: abort coincident with done on nonce 3
    m_cnt = m_cnt + 2;
    e = '0;
    e.nonce = 32'd3;
    e.cnt = 32'(m_cnt);
    exp_q.push_back(e);
    issue(rand512(), 256'd0, 32'd1, 32'd10, 3);
    hit = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (sha_done && sha_block[LSB +: 32] == 32'd3) begin
        hit = 1'b1;
        break;
      end
    end
    chk("t4 reached nonce 3 done", hit, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4 abort sha_reset", sha_reset, 1'b1);
    @(negedge clk);
    chk("t4 sha_reset one cycle", sha_reset, 1'b0);
    wait_idle(200);

    // 5: core drops its first done
    base = done_idx;
    drop_idx = done_idx;
`ifdef NONCE_SCHED_WATCHDOG_EN
    run_job(rand512(), '1, 32'h20, 32'h20, 4);
    chk("t5 retried after timeout", done_idx - base, 2);
`else
    e = '0;
    e.nonce = 32'h20;
    e.cnt = 32'(m_cnt);
    exp_q.push_back(e);
    issue(rand512(), '1, 32'h20, 32'h20, 4);
    repeat (100) @(negedge clk);
    chk("t5 busy while hung", busy, 1'b1);
    chk("t5 single done seen", done_idx - base, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle(200);
`endif
    drop_idx = -1;

    // 6: reset in the middle of WAIT
    issue(rand512(), 256'd0, 32'd100, 32'd200, 64);
    repeat (10) @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("t6 busy", busy, 1'b0);
    chk("t6 res_valid", res_valid, 1'b0);
    chk("t6 sha_start", sha_start, 1'b0);
    chk("t6 sha_reset", sha_reset, 1'b1);
    chk("t6 hash_count", hash_count, 32'd0);
    chk("t6 res_nonce", res_nonce, 32'd0);
    chk("t6 res_hash", res_hash, 256'd0);
    chk("t6 sha_block", sha_block, 512'd0);
    m_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6 job_ready after reset", job_ready, 1'b1);
    repeat (80) @(negedge clk);

    // Random jobs
    for (int j = 0; j < 8; j++) begin
      blk = rand512();
      tgt = {8{$urandom}};
      sel = $urandom_range(0, 3);
      tgt[255:224] = (sel == 0) ? 32'h0 : (sel == 1) ? 32'h2000_0000 :
                     (sel == 2) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      ns = ($urandom_range(0, 1) != 0) ? $urandom : (32'hFFFF_FFFF - $urandom_range(0, 3));
      ne = ns + $urandom_range(0, 4);
      run_job(blk, tgt, ns, ne, $urandom_range(1, 6));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
